// File: rtl/pulpemu_rst_ctrl.sv
`default_nettype none
// ============================================================================
// pulpemu_rst_ctrl : reset sequencer for the FPGA emulation top level
// Rev 1.0
// ============================================================================
module pulpemu_rst_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES = 32,
  parameter int SOC_HOLD_CYCLES    = 64,
  parameter int CL_DELAY_CYCLES    = 16,
  parameter int CNT_W              = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pad_reset_i,
  input  logic       pad_trst_ni,
  input  logic       mmcm_locked_i,
  output logic       soc_rst_no,
  output logic       cl_rst_no,
  output logic [2:0] state_o,
  output logic [1:0] cause_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(SOC_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CL_LOAD   = CNT_W'(CL_DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_SOC   = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  logic btn_meta, btn_sync, trst_meta, trst_sync, lock_meta, lock_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      trst_meta <= 1'b0;
      trst_sync <= 1'b0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      btn_meta  <= pad_reset_i;
      btn_sync  <= btn_meta;
      trst_meta <= pad_trst_ni;
      trst_sync <= trst_meta;
      lock_meta <= mmcm_locked_i;
      lock_sync <= lock_meta;
    end
  end

  logic             btn_db;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // lock_ok drops combinationally with lock_sync so a simultaneous lock loss
  // is seen in the same cycle as any other reset source.
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_ok, lock_ok_q;
  logic [7:0]       loss_cnt;

  assign lock_ok = lock_sync && (lock_cnt == LOCK_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_cnt  <= '0;
      lock_ok_q <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      lock_ok_q <= lock_ok;
      if (!lock_sync)
        lock_cnt <= '0;
      else if (lock_cnt != LOCK_MAX)
        lock_cnt <= lock_cnt + 1'b1;
      if (lock_ok_q && !lock_ok && (loss_cnt != 8'hFF))
        loss_cnt <= loss_cnt + 1'b1;
    end
  end

  logic sys_req;
  assign sys_req = btn_db | ~trst_sync | ~lock_ok;

  state_t           state, state_n;
  logic [CNT_W-1:0] seq_cnt, seq_cnt_n;
  logic [1:0]       cause, cause_n;

  always_comb begin
    state_n   = state;
    seq_cnt_n = seq_cnt;
    cause_n   = cause;
    case (state)
      ST_RESET: state_n = ST_WAIT;
      ST_WAIT: begin
        if (!sys_req) begin
          state_n   = ST_HOLD;
          seq_cnt_n = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (seq_cnt == '0) begin
          state_n   = ST_SOC;
          seq_cnt_n = CL_LOAD;
        end else begin
          seq_cnt_n = seq_cnt - 1'b1;
        end
      end
      ST_SOC: begin
        if (seq_cnt == '0)
          state_n = ST_RUN;
        else
          seq_cnt_n = seq_cnt - 1'b1;
      end
      ST_RUN:  state_n = ST_RUN;
      default: state_n = ST_WAIT;
    endcase
    // A fault overrides any counter expiry in the same cycle.
    if (sys_req && ((state == ST_HOLD) || (state == ST_SOC) || (state == ST_RUN))) begin
      state_n = ST_WAIT;
      if (!lock_ok)
        cause_n = 2'd2;
      else if (!trst_sync)
        cause_n = 2'd3;
      else
        cause_n = 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_RESET;
      seq_cnt    <= '0;
      cause      <= 2'd0;
      soc_rst_no <= 1'b0;
      cl_rst_no  <= 1'b0;
    end else begin
      state      <= state_n;
      seq_cnt    <= seq_cnt_n;
      cause      <= cause_n;
      soc_rst_no <= (state_n == ST_SOC) || (state_n == ST_RUN);
      cl_rst_no  <= (state_n == ST_RUN);
    end
  end

  assign state_o         = state;
  assign cause_o         = cause;
  assign lock_loss_cnt_o = loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_rst_ctrl.sv
`default_nettype none
// Testbench for pulpemu_rst_ctrl: table vectors, directed corner sequences and
// random pad activity compared every cycle against a run-length reference model.
module tb_pulpemu_rst_ctrl;

  localparam int DB   = 16;
  localparam int LK   = 32;
  localparam int HOLD = 64;
  localparam int CLD  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pad_btn = 1'b0;
  logic       pad_trst_n = 1'b1;
  logic       pad_lock = 1'b1;
  logic       soc_rst_no, cl_rst_no;
  logic [2:0] state_o;
  logic [1:0] cause_o;
  logic [7:0] lock_loss_cnt_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pulpemu_rst_ctrl #(
    .DEBOUNCE_CYCLES    (DB),
    .LOCK_STABLE_CYCLES (LK),
    .SOC_HOLD_CYCLES    (HOLD),
    .CL_DELAY_CYCLES    (CLD),
    .CNT_W              (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pad_reset_i     (pad_btn),
    .pad_trst_ni     (pad_trst_n),
    .mmcm_locked_i   (pad_lock),
    .soc_rst_no      (soc_rst_no),
    .cl_rst_no       (cl_rst_no),
    .state_o         (state_o),
    .cause_o         (cause_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model. The sequencer is described by q, the number of
  // consecutive clock edges on which no reset request was present.
  bit mp_btn, ms_btn, mp_trst, ms_trst, mp_lock, ms_lock, m_db, m_prev_ok, m_started;
  int m_dis, m_lrun, m_q, m_cause, m_llc;

  task automatic model_reset();
    mp_btn = 1; ms_btn = 1; mp_trst = 0; ms_trst = 0; mp_lock = 0; ms_lock = 0;
    m_db = 1; m_prev_ok = 0; m_started = 0;
    m_dis = 0; m_lrun = 0; m_q = 0; m_cause = 0; m_llc = 0;
  endtask

  task automatic model_step();
    bit ok, sys;
    ok = ms_lock && (m_lrun >= LK);
    if (m_prev_ok && !ok && m_llc < 255) m_llc++;
    m_prev_ok = ok;
    sys = m_db || !ms_trst || !ok;
    if (sys) begin
      if (m_q > 0) m_cause = !ok ? 2 : (!ms_trst ? 3 : 1);
      m_q = 0;
    end else if (m_q < 1000000) begin
      m_q++;
    end
    m_started = 1;
    if (ms_btn != m_db) begin
      m_dis++;
      if (m_dis == DB) begin
        m_db  = !m_db;
        m_dis = 0;
      end
    end else begin
      m_dis = 0;
    end
    m_lrun = ms_lock ? ((m_lrun < 1000000) ? m_lrun + 1 : m_lrun) : 0;
    ms_btn = mp_btn;   mp_btn = pad_btn;
    ms_trst = mp_trst; mp_trst = pad_trst_n;
    ms_lock = mp_lock; mp_lock = pad_lock;
  endtask

  function automatic logic [14:0] model_out();
    logic [2:0] st;
    if (!m_started)             st = 3'd0;
    else if (m_q == 0)          st = 3'd1;
    else if (m_q <= HOLD)       st = 3'd2;
    else if (m_q <= HOLD + CLD) st = 3'd3;
    else                        st = 3'd4;
    return {st, (m_q > HOLD), (m_q > HOLD + CLD), m_cause[1:0], m_llc[7:0]};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("cycle {state,soc,cl,cause,llc}",
              int'({state_o, soc_rst_no, cl_rst_no, cause_o, lock_loss_cnt_o}),
              int'(model_out()));
        check("cl_without_soc", int'(cl_rst_no & ~soc_rst_no), 0);
      end
    end
  end

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state_o) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_o), s);
  endtask

  typedef struct {
    int btn_len;
    int lock_len;
    int trst_len;
    bit exp_reseq;
    int exp_cause;
    int exp_llc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, maxlen, kind, len, idle;
    bit saw_low;

    tbl[0] = '{15, 0, 0, 1'b0, 0, 0};
    tbl[1] = '{16, 0, 0, 1'b1, 1, 0};
    tbl[2] = '{ 0, 1, 0, 1'b1, 2, 1};
    tbl[3] = '{ 0, 0, 1, 1'b1, 3, 1};
    tbl[4] = '{ 0, 1, 1, 1'b1, 2, 2};
    tbl[5] = '{ 1, 0, 0, 1'b0, 2, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst soc", int'(soc_rst_no), 0);
    check("rst cl", int'(cl_rst_no), 0);
    check("rst state", int'(state_o), 0);
    check("rst cause", int'(cause_o), 0);
    check("rst llc", int'(lock_loss_cnt_o), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Power-on sequence timing
    wait_state(2, 300, "por reach HOLD");
    n = 0;
    while (!soc_rst_no && n < 200) begin @(negedge clk); n++; end
    check("por hold length", n, HOLD);
    n = 0;
    while (!cl_rst_no && n < 200) begin @(negedge clk); n++; end
    check("por soc->cl delay", n, CLD);
    check("por cause", int'(cause_o), 0);

    // Table-driven pad events from RUN
    foreach (tbl[i]) begin
      wait_state(4, 400, "table pre RUN");
      maxlen = tbl[i].btn_len;
      if (tbl[i].lock_len > maxlen) maxlen = tbl[i].lock_len;
      if (tbl[i].trst_len > maxlen) maxlen = tbl[i].trst_len;
      saw_low = 1'b0;
      for (int k = 0; k < maxlen + 8; k++) begin
        pad_btn    = (k < tbl[i].btn_len);
        pad_lock   = !(k < tbl[i].lock_len);
        pad_trst_n = !(k < tbl[i].trst_len);
        @(negedge clk);
        if (!soc_rst_no) saw_low = 1'b1;
      end
      check($sformatf("table[%0d] reseq", i), int'(saw_low), int'(tbl[i].exp_reseq));
      wait_state(4, 400, $sformatf("table[%0d] back to RUN", i));
      check($sformatf("table[%0d] cause", i), int'(cause_o), tbl[i].exp_cause);
      check($sformatf("table[%0d] llc", i), int'(lock_loss_cnt_o), tbl[i].exp_llc);
    end

    // TRST while in SOC
    pad_trst_n = 1'b0;
    @(negedge clk);
    pad_trst_n = 1'b1;
    wait_state(3, 300, "trst reach SOC");
    pad_trst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("soc-trst soc", int'(soc_rst_no), 0);
    check("soc-trst cl", int'(cl_rst_no), 0);
    check("soc-trst state", int'(state_o), 1);
    check("soc-trst cause", int'(cause_o), 3);
    pad_trst_n = 1'b1;

    // Asynchronous reset in the middle of HOLD
    wait_state(2, 300, "async reach HOLD");
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async soc", int'(soc_rst_no), 0);
    check("async cl", int'(cl_rst_no), 0);
    check("async state", int'(state_o), 0);
    check("async cause", int'(cause_o), 0);
    check("async llc", int'(lock_loss_cnt_o), 0);
    #1 rst = 1'b0;

    // Random pad activity
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          len = $urandom_range(1, 20);
          pad_btn = 1'b1; repeat (len) @(negedge clk); pad_btn = 1'b0;
        end
        1: begin
          len = $urandom_range(1, 4);
          pad_lock = 1'b0; repeat (len) @(negedge clk); pad_lock = 1'b1;
        end
        2: begin
          len = $urandom_range(1, 3);
          pad_trst_n = 1'b0; repeat (len) @(negedge clk); pad_trst_n = 1'b1;
        end
        default: begin
          len = $urandom_range(1, 10);
          for (int k = 0; k < len; k++) begin
            pad_btn    = 1'($urandom_range(0, 1));
            pad_lock   = 1'($urandom_range(0, 1));
            pad_trst_n = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
          pad_btn = 1'b0; pad_lock = 1'b1; pad_trst_n = 1'b1;
        end
      endcase
      idle = $urandom_range(0, 150);
      repeat (idle) @(negedge clk);
    end

    // Lock-loss counter saturation
    pad_lock = 1'b1;
    repeat (40) @(negedge clk);
    for (int e = 0; e < 300; e++) begin
      pad_lock = 1'b0;
      @(negedge clk);
      pad_lock = 1'b1;
      repeat (36) @(negedge clk);
    end
    check("llc saturation", int'(lock_loss_cnt_o), 255);

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
